ds_stage_buf: RTL

- Next-generation dispatch stage. Sits between rename and the reservation stations (RSs).
- Registers one rename bundle of ID_WIDTH uops and dispatches it in order to N_RS reservation-station classes. Each class has DS_PORTS dispatch ports.
- Partial dispatch: the oldest dispatchable prefix leaves each cycle; the remainder is held. The previous generation dispatched all-or-nothing, one port per BR/MEM class.

---
 rtl/ds_stage_buf_pkg.sv | 35 +++
 rtl/ds_stage_buf_port_alloc.sv | 48 ++++
 rtl/ds_stage_buf.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ds_stage_buf_pkg.sv
// Shared types for the dispatch stage: CPU sizing defaults, uop payload and RS class encodings.
// Used by ds_stage_buf (optional DS_PERF_CNT_EN counters) and ds_port_alloc.
package ds_stage_buf_pkg;

    localparam int CPU_ID_WIDTH = 2;
    localparam int CPU_N_RS     = 4;
    localparam int CPU_DS_PORTS = 2;

    // RS_X sits outside 0..N_RS-1 so a slot carrying it can never be granted a port.
    typedef enum logic [2:0] {
        RS_INT  = 3'd0,
        RS_INTM = 3'd1,
        RS_BR   = 3'd2,
        RS_MEM  = 3'd3,
        RS_X    = 3'd7
    } rs_type_t;

    typedef struct packed {
        logic [7:0] opc;
        logic [5:0] pdst;
        logic [5:0] psrc1;
        logic [5:0] psrc2;
    } uop_t;

    typedef struct packed {
        logic     valid;
        rs_type_t rs_type;
        uop_t     uop;
    } slot_t;

    function automatic logic rs_type_legal(input rs_type_t t, input int nRs);
        return int'(t) < nRs;
    endfunction

endpackage

// File: rtl/ds_stage_buf_port_alloc.sv
// ds_port_alloc: combinational in-order prefix allocator; grants each slot a port within its RS class
// until the first slot that cannot go, which blocks every younger slot.
module ds_port_alloc
    import ds_stage_buf_pkg::*;
#(
    parameter int ID_WIDTH = CPU_ID_WIDTH,
    parameter int N_RS     = CPU_N_RS,
    parameter int DS_PORTS = CPU_DS_PORTS,
    parameter int FREE_W   = $clog2(DS_PORTS + 1),
    parameter int PIDX_W   = (DS_PORTS > 1) ? $clog2(DS_PORTS) : 1
) (
    input  logic     [ID_WIDTH-1:0]             slotValid_i,
    input  rs_type_t [ID_WIDTH-1:0]             slotType_i,
    input  logic     [N_RS-1:0][FREE_W-1:0]     rsFree_i,
    output logic     [ID_WIDTH-1:0]             dispatch_o,
    output logic     [ID_WIDTH-1:0][PIDX_W-1:0] portIdx_o,
    output logic                                allGo_o
);

    logic [N_RS-1:0][FREE_W-1:0] cnt;
    logic                        blocked;
    int                          cls;

    // cnt[r] is both the number of class-r grants so far and the port the next one lands on.
    always_comb begin
        cnt        = '0;
        blocked    = 1'b0;
        cls        = 0;
        dispatch_o = '0;
        portIdx_o  = '0;
        for (int i = 0; i < ID_WIDTH; i++) begin
            cls = int'(slotType_i[i]);
            if (slotValid_i[i] && !blocked) begin
                if (!rs_type_legal(slotType_i[i], N_RS)) begin
                    blocked = 1'b1;
                end else if (cnt[cls] < rsFree_i[cls]) begin
                    dispatch_o[i] = 1'b1;
                    portIdx_o[i]  = PIDX_W'(cnt[cls]);
                    cnt[cls]      = cnt[cls] + FREE_W'(1);
                end else begin
                    blocked = 1'b1;
                end
            end
        end
        allGo_o = !blocked;
    end

endmodule

// File: rtl/ds_stage_buf.sv
// ds_stage_buf: one-bundle dispatch buffer with partial in-order dispatch to N_RS classes of DS_PORTS ports.
// Define DS_PERF_CNT_EN to add the internal perf_block_cnt / perf_partial_cnt saturating counters.
module ds_stage_buf
    import ds_stage_buf_pkg::*;
#(
    parameter int ID_WIDTH = CPU_ID_WIDTH,
    parameter int N_RS     = CPU_N_RS,
    parameter int DS_PORTS = CPU_DS_PORTS,
    parameter int FREE_W   = $clog2(DS_PORTS + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                prv_valid,
    output logic                                prv_ready,
    input  logic     [ID_WIDTH-1:0]             uops_valid,
    input  rs_type_t [ID_WIDTH-1:0]             rs_type,
    input  uop_t     [ID_WIDTH-1:0]             uops,
    input  logic     [N_RS-1:0][FREE_W-1:0]     rs_free,
    output logic     [N_RS-1:0][DS_PORTS-1:0]   rs_valid,
    output uop_t     [N_RS-1:0][DS_PORTS-1:0]   rs_uop
);

    localparam int PIDX_W = (DS_PORTS > 1) ? $clog2(DS_PORTS) : 1;

    slot_t    [ID_WIDTH-1:0]             slots_q;
    slot_t    [ID_WIDTH-1:0]             slots_d;
    logic     [ID_WIDTH-1:0]             slotValid;
    rs_type_t [ID_WIDTH-1:0]             slotType;
    logic     [ID_WIDTH-1:0]             dispatchGo;
    logic     [ID_WIDTH-1:0][PIDX_W-1:0] portIdx;
    logic                                allGo;
    logic                                kill;

    always_comb begin
        slotValid = '0;
        slotType  = '0;
        for (int i = 0; i < ID_WIDTH; i++) begin
            slotValid[i] = slots_q[i].valid;
            slotType[i]  = slots_q[i].rs_type;
        end
    end

    ds_port_alloc #(
        .ID_WIDTH (ID_WIDTH),
        .N_RS     (N_RS),
        .DS_PORTS (DS_PORTS),
        .FREE_W   (FREE_W),
        .PIDX_W   (PIDX_W)
    ) u_alloc (
        .slotValid_i (slotValid),
        .slotType_i  (slotType),
        .rsFree_i    (rs_free),
        .dispatch_o  (dispatchGo),
        .portIdx_o   (portIdx),
        .allGo_o     (allGo)
    );

    // A reset cycle is treated like a flush: nothing leaves and any offered bundle is dropped.
    assign kill      = flush || rst;
    assign prv_ready = kill || allGo;

    always_comb begin
        rs_valid = '0;
        rs_uop   = '0;
        for (int r = 0; r < N_RS; r++) begin
            for (int p = 0; p < DS_PORTS; p++) begin
                for (int i = 0; i < ID_WIDTH; i++) begin
                    if (!kill && dispatchGo[i] && int'(slots_q[i].rs_type) == r
                        && int'(portIdx[i]) == p) begin
                        rs_valid[r][p] = 1'b1;
                        rs_uop[r][p]   = slots_q[i].uop;
                    end
                end
            end
        end
    end

    // Slots never compact: a held slot keeps its index so program order stays implicit.
    always_comb begin
        slots_d = slots_q;
        for (int i = 0; i < ID_WIDTH; i++) begin
            if (dispatchGo[i]) begin
                slots_d[i].valid = 1'b0;
            end
        end
        if (kill) begin
            for (int i = 0; i < ID_WIDTH; i++) begin
                slots_d[i].valid = 1'b0;
            end
        end else if (prv_valid && allGo) begin
            for (int i = 0; i < ID_WIDTH; i++) begin
                slots_d[i].valid   = uops_valid[i];
                slots_d[i].rs_type = rs_type[i];
                slots_d[i].uop     = uops[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ID_WIDTH; i++) begin
                if (slots_q[i].valid) begin
                    assert (rs_type_legal(slots_q[i].rs_type, N_RS));
                end
            end
        end
    end

`ifdef DS_PERF_CNT_EN
    logic [31:0] perf_block_cnt [N_RS];
    logic [31:0] perf_partial_cnt;
    logic        headFound;
    logic        headBlocked;
    int          headCls;
    logic        partialEvt;

    // Only the oldest valid slot is charged; a blocked younger slot behind a dispatching head is a partial.
    always_comb begin
        headFound   = 1'b0;
        headBlocked = 1'b0;
        headCls     = 0;
        for (int i = 0; i < ID_WIDTH; i++) begin
            if (slots_q[i].valid && !headFound) begin
                headFound   = 1'b1;
                headBlocked = !dispatchGo[i];
                headCls     = int'(slots_q[i].rs_type);
            end
        end
        partialEvt = !kill && (|dispatchGo) && (|(slotValid & ~dispatchGo));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N_RS; r++) begin
                perf_block_cnt[r] <= '0;
            end
            perf_partial_cnt <= '0;
        end else begin
            for (int r = 0; r < N_RS; r++) begin
                if (headBlocked && headCls == r && perf_block_cnt[r] != '1) begin
                    perf_block_cnt[r] <= perf_block_cnt[r] + 32'd1;
                end
            end
            if (partialEvt && perf_partial_cnt != '1) begin
                perf_partial_cnt <= perf_partial_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
